// File: rtl/branch_resolve_unit_if.sv
// Bundle of the pipeline-facing signals of the branch resolve unit.
//
// master: pipeline side. It drives fetch-side predictions, stall and the EX branch
//         outcome, and receives redirect, predictor update and statistics.
// slave:  branch_resolve_unit side (the mirror image of master).
//
// Signals:
//   if_valid/if_pc/pred_taken/pred_target   fetch-stage instruction and its prediction
//   stall                                   IF/ID hold, bubble into EX
//   ex_is_branch/ex_taken/ex_target         actual outcome of the EX instruction
//   redirect_valid/redirect_pc/flush        combinational correct-path redirect
//   mispredict_type                         00 none, 10 missed taken, 11 false taken,
//                                           01 wrong target
//   upd_set/upd_iaddr/upd_taken/upd_target  registered predictor update pulse
//   recovering                              unit waits for the refetch to reach EX
//   stat_branches/stat_mispredicts/stat_penalty  statistics counters
interface branch_resolve_unit_if #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 if_valid;
  logic [PC_WIDTH-1:0]  if_pc;
  logic                 pred_taken;
  logic [PC_WIDTH-1:0]  pred_target;
  logic                 stall;
  logic                 ex_is_branch;
  logic                 ex_taken;
  logic [PC_WIDTH-1:0]  ex_target;

  logic                 redirect_valid;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic                 flush;
  logic [1:0]           mispredict_type;
  logic                 upd_set;
  logic [PC_WIDTH-1:0]  upd_iaddr;
  logic                 upd_taken;
  logic [PC_WIDTH-1:0]  upd_target;
  logic                 recovering;
  logic [CNT_WIDTH-1:0] stat_branches;
  logic [CNT_WIDTH-1:0] stat_mispredicts;
  logic [CNT_WIDTH-1:0] stat_penalty;

  modport master (
    output if_valid, if_pc, pred_taken, pred_target, stall, ex_is_branch, ex_taken, ex_target,
    input  redirect_valid, redirect_pc, flush, mispredict_type, upd_set, upd_iaddr, upd_taken,
           upd_target, recovering, stat_branches, stat_mispredicts, stat_penalty
  );

  modport slave (
    input  if_valid, if_pc, pred_taken, pred_target, stall, ex_is_branch, ex_taken, ex_target,
    output redirect_valid, redirect_pc, flush, mispredict_type, upd_set, upd_iaddr, upd_taken,
           upd_target, recovering, stat_branches, stat_mispredicts, stat_penalty
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution unit.
//
// Carries each fetched instruction's prediction (taken bit, target) through shadow stages
// s_id and s_ex alongside the real pipeline, compares it with the actual outcome in EX,
// raises a combinational redirect/flush on a mismatch and issues a registered predictor
// update for every resolved branch.
//
// Ports:
//   clk  clock, all state on posedge
//   rst  asynchronous active-high reset
//   bus  branch_resolve_unit_if.slave (see interface header for signal list)
//
// Optional feature: define BRU_STATS_EN to compile in saturating statistics counters.
// Without it the three stat outputs are tied to zero and no counter flops exist.
module branch_resolve_unit #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic {StIdle, StRecover} state_e;

  // Shadow stages
  logic                s_id_valid_q, s_ex_valid_q;
  logic [PC_WIDTH-1:0] s_id_pc_q, s_ex_pc_q;
  logic                s_id_ptaken_q, s_ex_ptaken_q;
  logic [PC_WIDTH-1:0] s_id_ptarget_q, s_ex_ptarget_q;
  logic                s_ex_valid_d;

  // Resolution
  logic                resolve;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [1:0]          mispredict_type;

  // Predictor update
  logic                upd_set_q, upd_taken_q;
  logic [PC_WIDTH-1:0] upd_iaddr_q, upd_target_q;

  state_e state_q, state_d;

  // A bubble in EX never resolves, whatever ex_is_branch says.
  assign resolve = s_ex_valid_q & bus.ex_is_branch;

  always_comb begin
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    mispredict_type = 2'b00;
    if (resolve) begin
      if (bus.ex_taken && !s_ex_ptaken_q) begin
        redirect_valid  = 1'b1;
        mispredict_type = 2'b10;
        redirect_pc     = bus.ex_target;
      end else if (!bus.ex_taken && s_ex_ptaken_q) begin
        redirect_valid  = 1'b1;
        mispredict_type = 2'b11;
        // Fall-through address wraps at the top of the address space.
        redirect_pc     = s_ex_pc_q + PC_WIDTH'(4);
      end else if (bus.ex_taken && (s_ex_ptarget_q != bus.ex_target)) begin
        redirect_valid  = 1'b1;
        mispredict_type = 2'b01;
        redirect_pc     = bus.ex_target;
      end
    end
  end

  // Flush beats stall; stall holds ID and feeds a bubble into EX.
  assign s_ex_valid_d = !redirect_valid && !bus.stall && s_id_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_id_valid_q   <= 1'b0;
      s_id_pc_q      <= '0;
      s_id_ptaken_q  <= 1'b0;
      s_id_ptarget_q <= '0;
      s_ex_valid_q   <= 1'b0;
      s_ex_pc_q      <= '0;
      s_ex_ptaken_q  <= 1'b0;
      s_ex_ptarget_q <= '0;
    end else begin
      s_ex_valid_q <= s_ex_valid_d;
      if (redirect_valid) begin
        s_id_valid_q <= 1'b0;
      end else if (!bus.stall) begin
        s_ex_pc_q      <= s_id_pc_q;
        s_ex_ptaken_q  <= s_id_ptaken_q;
        s_ex_ptarget_q <= s_id_ptarget_q;
        s_id_valid_q   <= bus.if_valid;
        s_id_pc_q      <= bus.if_pc;
        s_id_ptaken_q  <= bus.pred_taken;
        s_id_ptarget_q <= bus.pred_target;
      end
    end
  end

  // One update pulse per resolved branch, correct or not; data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_set_q    <= 1'b0;
      upd_iaddr_q  <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
    end else begin
      upd_set_q <= resolve;
      if (resolve) begin
        upd_iaddr_q  <= s_ex_pc_q;
        upd_taken_q  <= bus.ex_taken;
        upd_target_q <= bus.ex_target;
      end
    end
  end

  // RECOVER lasts until the first correct-path instruction enters EX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (redirect_valid) state_d = StRecover;
      end
      StRecover: begin
        if (!redirect_valid && s_ex_valid_d) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  assign bus.redirect_valid  = redirect_valid;
  assign bus.redirect_pc     = redirect_pc;
  assign bus.flush           = redirect_valid;
  assign bus.mispredict_type = mispredict_type;
  assign bus.upd_set         = upd_set_q;
  assign bus.upd_iaddr       = upd_iaddr_q;
  assign bus.upd_taken       = upd_taken_q;
  assign bus.upd_target      = upd_target_q;
  assign bus.recovering      = (state_q == StRecover);

`ifdef BRU_STATS_EN
  logic [CNT_WIDTH-1:0] stat_branches_q, stat_mispredicts_q, stat_penalty_q;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      stat_penalty_q     <= '0;
    end else begin
      if (resolve && !(&stat_branches_q)) begin
        stat_branches_q <= stat_branches_q + CNT_WIDTH'(1);
      end
      if (redirect_valid && !(&stat_mispredicts_q)) begin
        stat_mispredicts_q <= stat_mispredicts_q + CNT_WIDTH'(1);
      end
      if ((state_q == StRecover) && !(&stat_penalty_q)) begin
        stat_penalty_q <= stat_penalty_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
  assign bus.stat_penalty     = stat_penalty_q;
`else
  assign bus.stat_branches    = {CNT_WIDTH{1'b0}};
  assign bus.stat_mispredicts = {CNT_WIDTH{1'b0}};
  assign bus.stat_penalty     = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios followed by randomized traffic.
// A driver issues one cycle of stimulus at a time, advances a reference model of the
// prediction-tracking pipeline and pushes the expected outputs into a queue; a monitor
// pops one entry per cycle at the falling edge and compares it with the DUT.
module tb_branch_resolve_unit;
  localparam int unsigned PW   = 32;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
`ifdef BRU_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  branch_resolve_unit #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          pt;
    logic [31:0] ptg;
  } slot_t;

  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    logic [1:0]  mt;
    bit          us;
    logic [31:0] ua;
    bit          ut;
    logic [31:0] utg;
    bit          rec;
    int          sb;
    int          sm;
    int          sp;
  } exp_t;

  exp_t  expq[$];
  exp_t  last_e;
  slot_t m_id, m_ex;
  bit    m_rec, m_us, m_ut;
  logic [31:0] m_ua, m_utg;
  int    m_sb, m_sm, m_sp;
  int    checks = 0;
  int    passes = 0;

  task automatic chk(input string name, input bit ok, input string got, input string exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %s, expected %s", name, got, exp);
  endtask

  task automatic model_reset();
    m_id  = '{1'b0, 32'd0, 1'b0, 32'd0};
    m_ex  = '{1'b0, 32'd0, 1'b0, 32'd0};
    m_rec = 1'b0;
    m_us  = 1'b0;
    m_ut  = 1'b0;
    m_ua  = '0;
    m_utg = '0;
    m_sb  = 0;
    m_sm  = 0;
    m_sp  = 0;
  endtask

  // Classify the branch currently in EX against its recorded prediction.
  task automatic outcome(output bit rv, output logic [31:0] rpc, output logic [1:0] mt);
    rv  = 1'b0;
    rpc = '0;
    mt  = 2'b00;
    if (m_ex.v && bus.ex_is_branch) begin
      if (bus.ex_taken && !m_ex.pt) begin
        rv = 1'b1; mt = 2'b10; rpc = bus.ex_target;
      end else if (!bus.ex_taken && m_ex.pt) begin
        rv = 1'b1; mt = 2'b11; rpc = m_ex.pc + 32'd4;
      end else if (bus.ex_taken && (m_ex.ptg != bus.ex_target)) begin
        rv = 1'b1; mt = 2'b01; rpc = bus.ex_target;
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_edge();
    bit rv;
    bit res;
    logic [31:0] rpc;
    logic [1:0]  mt;
    if (rst) begin
      model_reset();
      return;
    end
    outcome(rv, rpc, mt);
    res = m_ex.v && bus.ex_is_branch;
    if (res && m_sb < CMAX) m_sb++;
    if (rv && m_sm < CMAX) m_sm++;
    if (m_rec && m_sp < CMAX) m_sp++;
    m_us = res;
    if (res) begin
      m_ua  = m_ex.pc;
      m_ut  = bus.ex_taken;
      m_utg = bus.ex_target;
    end
    if (rv) begin
      m_id.v = 1'b0;
      m_ex.v = 1'b0;
    end else if (bus.stall) begin
      m_ex.v = 1'b0;
    end else begin
      m_ex = m_id;
      m_id = '{bus.if_valid, bus.if_pc, bus.pred_taken, bus.pred_target};
    end
    if (rv) m_rec = 1'b1;
    else if (m_ex.v) m_rec = 1'b0;
  endtask

  // One clock cycle of stimulus; the expected outputs for that cycle go to the queue.
  task automatic cycle(input bit r, input bit iv, input logic [31:0] ipc, input bit pt,
                       input logic [31:0] ptg, input bit st, input bit isb, input bit tk,
                       input logic [31:0] tg);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst = r;
    if (r) model_reset();
    bus.if_valid     = iv;
    bus.if_pc        = ipc;
    bus.pred_taken   = pt;
    bus.pred_target  = ptg;
    bus.stall        = st;
    bus.ex_is_branch = isb;
    bus.ex_taken     = tk;
    bus.ex_target    = tg;
    outcome(e.rv, e.rpc, e.mt);
    e.us  = m_us;
    e.ua  = m_ua;
    e.ut  = m_ut;
    e.utg = m_utg;
    e.rec = m_rec;
    e.sb  = StatsEn ? m_sb : 0;
    e.sm  = StatsEn ? m_sm : 0;
    e.sp  = StatsEn ? m_sp : 0;
    expq.push_back(e);
    last_e = e;
  endtask

  task automatic idle(input bit st);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, st, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic ex_branch(input bit st, input bit tk, input logic [31:0] tg);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, st, 1'b1, tk, tg);
  endtask

  task automatic fetch(input logic [31:0] pc, input bit pt, input logic [31:0] ptg);
    cycle(1'b0, 1'b1, pc, pt, ptg, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("redirect",
            bus.redirect_valid === e.rv && bus.flush === e.rv && bus.redirect_pc === e.rpc &&
            bus.mispredict_type === e.mt,
            $sformatf("rv=%b fl=%b pc=%h type=%b", bus.redirect_valid, bus.flush,
                      bus.redirect_pc, bus.mispredict_type),
            $sformatf("rv=%b fl=%b pc=%h type=%b", e.rv, e.rv, e.rpc, e.mt));
        chk("update",
            bus.upd_set === e.us && bus.upd_iaddr === e.ua && bus.upd_taken === e.ut &&
            bus.upd_target === e.utg,
            $sformatf("set=%b ia=%h tk=%b tg=%h", bus.upd_set, bus.upd_iaddr, bus.upd_taken,
                      bus.upd_target),
            $sformatf("set=%b ia=%h tk=%b tg=%h", e.us, e.ua, e.ut, e.utg));
        chk("fsm_stats",
            bus.recovering === e.rec && bus.stat_branches === CW'(e.sb) &&
            bus.stat_mispredicts === CW'(e.sm) && bus.stat_penalty === CW'(e.sp),
            $sformatf("rec=%b br=%0d mp=%0d pen=%0d", bus.recovering, bus.stat_branches,
                      bus.stat_mispredicts, bus.stat_penalty),
            $sformatf("rec=%b br=%0d mp=%0d pen=%0d", e.rec, e.sb, e.sm, e.sp));
      end
    end
  end

  initial begin
    bus.if_valid     = 1'b0;
    bus.if_pc        = '0;
    bus.pred_taken   = 1'b0;
    bus.pred_target  = '0;
    bus.stall        = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_taken     = 1'b0;
    bus.ex_target    = '0;
    model_reset();

    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h55);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(1'b0);

    // Missed taken at 0x100 -> 0x200, refetch follows
    fetch(32'h100, 1'b0, 32'h0);
    idle(1'b0);
    ex_branch(1'b0, 1'b1, 32'h200);
    fetch(32'h200, 1'b0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // False taken at the top of the address space: fall-through wraps to 0
    fetch(32'hFFFF_FFFC, 1'b1, 32'h40);
    idle(1'b0);
    ex_branch(1'b0, 1'b0, 32'h40);
    fetch(32'h0, 1'b0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Wrong target, then a correctly predicted taken branch
    fetch(32'h80, 1'b1, 32'h300);
    idle(1'b0);
    ex_branch(1'b0, 1'b1, 32'h340);
    fetch(32'h340, 1'b0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    fetch(32'h90, 1'b1, 32'h300);
    idle(1'b0);
    ex_branch(1'b0, 1'b1, 32'h300);
    idle(1'b0);

    // Stall while B resolves in EX and A sits in ID; bubble in EX must not resolve
    fetch(32'h500, 1'b0, 32'h0);
    fetch(32'h600, 1'b1, 32'h700);
    ex_branch(1'b1, 1'b0, 32'h504);
    ex_branch(1'b0, 1'b1, 32'h999);
    ex_branch(1'b0, 1'b1, 32'h700);
    idle(1'b0);

    // Reset while an update pulse is pending
    fetch(32'h800, 1'b0, 32'h0);
    idle(1'b0);
    ex_branch(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(1'b0);
    idle(1'b0);

    // 20 consecutive mispredicts drive the counters into saturation
    for (int i = 0; i < 20; i++) begin
      fetch(32'h1000 + 32'(i * 16), 1'b0, 32'h0);
      idle(1'b0);
      ex_branch(1'b0, 1'b1, 32'h2000 + 32'(i * 64));
    end
    idle(1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(1'b0);

    // Randomized traffic; fetch follows redirects most of the time
    for (int i = 0; i < 3000; i++) begin
      bit iv, pt, st, isb, tk, r;
      logic [31:0] ipc, ptg, tg;
      r   = ($urandom_range(0, 299) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      ipc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      if (last_e.rv && $urandom_range(0, 3) != 0) begin
        iv  = 1'b1;
        ipc = last_e.rpc;
      end
      pt  = $urandom_range(0, 1) == 1;
      ptg = ($urandom_range(0, 1) == 1) ? 32'h4000 : 32'h8000;
      st  = ($urandom_range(0, 4) == 0);
      isb = ($urandom_range(0, 4) < 3);
      tk  = $urandom_range(0, 1) == 1;
      tg  = ($urandom_range(0, 1) == 1) ? 32'h4000 : 32'h8000;
      cycle(r, iv, ipc, pt, ptg, st, isb, tk, tg);
    end
    idle(1'b0);
    idle(1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

EX-stage branch resolution unit; the update-side partner of the branch predictor. It carries each fetched instruction's prediction (taken bit, target) through IF→ID→EX in shadow registers and compares it with the actual branch outcome in EX. On a mismatch it raises a redirect and flush. For every resolved branch it issues the predictor update (set, address, taken, target) and reports the error class.

## Interface
- PC_WIDTH, 32, instruction address width
- CNT_WIDTH, 16, statistics counter width
- clk  in  1  clock; all state on posedge
- rst  in  1  reset; asynchronous, active-high
- if_valid  in  1  instruction in IF is valid
- if_pc  in  PC_WIDTH  address of the IF instruction
- pred_taken  in  1  predictor's taken bit for if_pc, same cycle as if_valid
- pred_target  in  PC_WIDTH  predictor's target for if_pc
- stall  in  1  pipeline holds IF/ID; ID/EX receives a bubble
- ex_is_branch  in  1  instruction in EX is a conditional branch
- ex_taken  in  1  actual outcome of the EX branch
- ex_target  in  PC_WIDTH  actual target of the EX branch
- redirect_valid  out  1  combinational; fetch must load redirect_pc next edge
- redirect_pc  out  PC_WIDTH  combinational correct-path PC
- flush  out  1  combinational; equal to redirect_valid, kills IF and ID
- mispredict_type  out  2  combinational: 00 none, 10 missed taken, 11 false taken, 01 wrong target
- upd_set  out  1  registered one-cycle pulse: update predictor
- upd_iaddr  out  PC_WIDTH  registered branch address
- upd_taken  out  1  registered actual outcome
- upd_target  out  PC_WIDTH  registered actual target (ex_target)
- recovering  out  1  FSM is in RECOVER
- stat_branches, stat_mispredicts, stat_penalty  out  CNT_WIDTH each  statistics

## Operation
- Shadow stages are s_id and s_ex, each holding {valid, pc, ptaken, ptarget}. Each posedge, in priority order:
  - flush: s_id.valid ← 0 and s_ex.valid ← 0.
  - stall: s_id holds; s_ex.valid ← 0.
  - otherwise: s_ex ← s_id; s_id ← {if_valid, if_pc, pred_taken, pred_target}.
- A branch resolves when s_ex.valid && ex_is_branch. Outcomes:
  - ex_taken && !ptaken → type 10, redirect_pc = ex_target.
  - !ex_taken && ptaken → type 11, redirect_pc = s_ex.pc + 4, truncated to PC_WIDTH (wraps at 2^PC_WIDTH).
  - ex_taken && ptaken && ptarget != ex_target → type 01, redirect_pc = ex_target.
  - Otherwise no redirect.
- When no branch resolves, redirect_valid, flush and mispredict_type are all 0, and redirect_pc is 0.
- Predictor update: at the posedge after a resolving cycle, upd_set ← 1 and upd_iaddr/upd_taken/upd_target ← s_ex.pc/ex_taken/ex_target. In all other cycles upd_set ← 0 and the data fields hold their last values. Every resolved branch produces exactly one upd_set pulse, including correctly predicted ones.
- FSM:
  - IDLE → RECOVER on redirect_valid.
  - RECOVER → IDLE at the first edge where s_ex.valid = 1, meaning the first correct-path instruction has reached EX.
  - A redirect seen while in RECOVER keeps the FSM in RECOVER.
  - recovering = (state == RECOVER).

## Timing
- Resolution-to-redirect latency is 0 cycles (combinational). Update latency is 1 cycle.
- Each upd_set pulse is 1 cycle wide. The predictor samples it on the following edge.
- Reset: every output is 0; s_id and s_ex are invalid; FSM is IDLE; statistics are 0. A pending update is dropped; no upd_set follows reset.
- Stall and redirect in the same cycle: flush wins, and the shadow stages are invalidated.
- A branch in EX during stall is still resolved: EX is not held, only IF/ID.
- Bubble in EX (s_ex.valid = 0): ex_is_branch is ignored.

## Configuration
- BRU_STATS_EN defined, counters compiled in:
  - stat_branches increments per resolved branch.
  - stat_mispredicts increments per redirect.
  - stat_penalty increments each cycle in RECOVER.
  - All counters saturate at all-ones and clear only on rst.
- BRU_STATS_EN undefined: no counter flops; all three outputs are tied to 0. Other behaviour is identical.

## Test plan
- rst mid-run with upd_set pending → all outputs 0 within the reset cycle; no upd_set after release; stats 0.
- Branch at 0x100, pred_taken=0, ex_taken=1, ex_target=0x200 → same cycle: redirect_valid=1, redirect_pc=0x200, type=10, flush=1. Next cycle: upd_set=1, upd_iaddr=0x100, upd_taken=1, upd_target=0x200.
- Branch at 0xFFFFFFFC predicted taken to 0x40, actual not taken → redirect_pc=0x00000000, type=11. FSM enters RECOVER and stays 2 cycles until the refetch reaches EX. With BRU_STATS_EN, stat_penalty=2.
- Branch predicted taken to 0x300, actual taken to 0x340 → type=01, redirect_pc=0x340. Branch predicted taken to 0x300, actual to 0x300 → no redirect; one upd_set with upd_taken=1.
- stall=1 on the edge where branch A moves ID→EX, with a resolving branch B in EX → B resolves and updates; A holds in s_id; s_ex receives a bubble. After stall drops, A resolves exactly once (one upd_set).
- With BRU_STATS_EN and CNT_WIDTH=4, 20 consecutive mispredicts → stat_mispredicts=15 and stat_branches=15 (saturated). Without BRU_STATS_EN → all stat outputs 0.
